// File: rtl/euclidean_top2_selector_pkg.sv
// euclid_pkg: shared definitions for the top-2 Euclidean selector family.
//   - default widths for the word index, distance and frame size
//   - FSM state encoding (accumulate / hold result)
//   - all-ones distance used as the "no candidate yet" sentinel
package euclid_pkg;

    localparam int WORD_W_DEF    = 4;
    localparam int DIST_W_DEF    = 64;
    localparam int MAX_WORDS_DEF = 16;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    localparam logic [DIST_W_DEF-1:0] DIST_MAX = '1;

endpackage

// File: rtl/euclidean_top2_selector_top2_update.sv
// top2_update: combinational insertion of one candidate into a best/second pair.
// Ports:
//   best_word/best_dist, second_word/second_dist  current pair
//   cand_word/cand_dist                           candidate under test
//   next_*                                        updated pair
// Ties go to the candidate: "<=" lets a later equal distance displace the
// earlier one, and the displaced best drops into the second slot.
module top2_update #(
    parameter int WORD_W = 4,
    parameter int DIST_W = 64
) (
    input  logic [WORD_W-1:0] best_word,
    input  logic [DIST_W-1:0] best_dist,
    input  logic [WORD_W-1:0] second_word,
    input  logic [DIST_W-1:0] second_dist,
    input  logic [WORD_W-1:0] cand_word,
    input  logic [DIST_W-1:0] cand_dist,
    output logic [WORD_W-1:0] next_best_word,
    output logic [DIST_W-1:0] next_best_dist,
    output logic [WORD_W-1:0] next_second_word,
    output logic [DIST_W-1:0] next_second_dist
);

    always_comb begin
        next_best_word   = best_word;
        next_best_dist   = best_dist;
        next_second_word = second_word;
        next_second_dist = second_dist;
        if (cand_dist <= best_dist) begin
            next_second_word = best_word;
            next_second_dist = best_dist;
            next_best_word   = cand_word;
            next_best_dist   = cand_dist;
        end else if (cand_dist <= second_dist) begin
            next_second_word = cand_word;
            next_second_dist = cand_dist;
        end
    end

endmodule

// File: rtl/euclidean_top2_selector.sv
// euclidean_top2_selector: frame-based best / second-best distance tracker.
// Accepts (iword, idata) candidates while accumulating; the candidate flagged
// with ilast closes the frame and the result is held behind a valid/ready
// handshake until the downstream takes it, after which state is cleared.
// Ports:
//   iclk, irstn                 clock, synchronous active-low reset
//   iword, idata, ivalid, ilast candidate stream
//   oready                      candidate accepted this cycle when ivalid=1
//   ovalid, iready              result handshake
//   oword, odist                best match
//   osecond_word, osecond_dist  second-best match
//   ocount                      accepted candidates (saturates at MAX_WORDS)
//   ooverflow                   more than MAX_WORDS candidates in the frame
// Optional (macro EUCLID_MARGIN_REJECT_EN):
//   imargin                     static minimum separation between best and second
//   oreject                     result is ambiguous (separation below imargin)
module euclidean_top2_selector
    import euclid_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int DIST_W    = DIST_W_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF
`ifdef EUCLID_MARGIN_REJECT_EN
    ,
    parameter int MARGIN_W  = 32
`endif
) (
    input  logic                             iclk,
    input  logic                             irstn,
    input  logic [WORD_W-1:0]                iword,
    input  logic [DIST_W-1:0]                idata,
    input  logic                             ivalid,
    input  logic                             ilast,
    output logic                             oready,
    output logic                             ovalid,
    input  logic                             iready,
    output logic [WORD_W-1:0]                oword,
    output logic [DIST_W-1:0]                odist,
    output logic [WORD_W-1:0]                osecond_word,
    output logic [DIST_W-1:0]                osecond_dist,
    output logic [$clog2(MAX_WORDS+1)-1:0]   ocount,
    output logic                             ooverflow
`ifdef EUCLID_MARGIN_REJECT_EN
    ,
    input  logic [MARGIN_W-1:0]              imargin,
    output logic                             oreject
`endif
);

    localparam int CNT_W = $clog2(MAX_WORDS+1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   best_word_q, best_word_d;
    logic [DIST_W-1:0]   best_dist_q, best_dist_d;
    logic [WORD_W-1:0]   second_word_q, second_word_d;
    logic [DIST_W-1:0]   second_dist_q, second_dist_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;

    logic [WORD_W-1:0]   upd_best_word;
    logic [DIST_W-1:0]   upd_best_dist;
    logic [WORD_W-1:0]   upd_second_word;
    logic [DIST_W-1:0]   upd_second_dist;
    logic                accept;

    top2_update #(
        .WORD_W (WORD_W),
        .DIST_W (DIST_W)
    ) u_update (
        .best_word        (best_word_q),
        .best_dist        (best_dist_q),
        .second_word      (second_word_q),
        .second_dist      (second_dist_q),
        .cand_word        (iword),
        .cand_dist        (idata),
        .next_best_word   (upd_best_word),
        .next_best_dist   (upd_best_dist),
        .next_second_word (upd_second_word),
        .next_second_dist (upd_second_dist)
    );

    assign oready       = (state_q == ST_ACCUM);
    assign ovalid       = (state_q == ST_HOLD);
    assign accept       = oready && ivalid;
    assign oword        = best_word_q;
    assign odist        = best_dist_q;
    assign osecond_word = second_word_q;
    assign osecond_dist = second_dist_q;
    assign ocount       = count_q;
    assign ooverflow    = overflow_q;

    always_comb begin
        state_d       = state_q;
        best_word_d   = best_word_q;
        best_dist_d   = best_dist_q;
        second_word_d = second_word_q;
        second_dist_d = second_dist_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    best_word_d   = upd_best_word;
                    best_dist_d   = upd_best_dist;
                    second_word_d = upd_second_word;
                    second_dist_d = upd_second_dist;
                    // Saturating count; the candidate is still compared above.
                    if (count_q == CNT_MAX) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (ilast) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (iready) begin
                    state_d       = ST_ACCUM;
                    best_word_d   = '0;
                    best_dist_d   = '1;
                    second_word_d = '0;
                    second_dist_d = '1;
                    count_d       = '0;
                    overflow_d    = 1'b0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!irstn) begin
            state_q       <= ST_ACCUM;
            best_word_q   <= '0;
            best_dist_q   <= '1;
            second_word_q <= '0;
            second_dist_q <= '1;
            count_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            best_word_q   <= best_word_d;
            best_dist_q   <= best_dist_d;
            second_word_q <= second_word_d;
            second_dist_q <= second_dist_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
        end
    end

`ifdef EUCLID_MARGIN_REJECT_EN
    logic              reject_q, reject_d;
    logic [DIST_W:0]   margin_gap;

    // Evaluated on the next-state pair so the flag lands together with ovalid.
    // One extra bit keeps the subtraction from wrapping.
    assign margin_gap = {1'b0, second_dist_d} - {1'b0, best_dist_d};
    assign oreject    = reject_q;

    always_comb begin
        reject_d = reject_q;
        if (state_q == ST_ACCUM && state_d == ST_HOLD) begin
            reject_d = (margin_gap < (DIST_W+1)'(imargin)) || (count_d == '0);
        end else if (state_q == ST_HOLD && state_d == ST_ACCUM) begin
            reject_d = 1'b0;
        end
    end

    always_ff @(posedge iclk) begin
        if (!irstn) begin
            reject_q <= 1'b0;
        end else begin
            reject_q <= reject_d;
        end
    end
`endif

endmodule
